// File: rtl/maze_pkg.sv
// Shared definitions for the maze solver controller.
//   - direction codes (probe order up, right, down, left)
//   - FSM state constants
//   - opposite(): reverse of a step direction
//   - neighbour(): adjacent cell plus an in-bounds flag. Coordinates are
//     carried at a fixed width CW so that one function serves any N.
package maze_pkg;

    localparam int CW = 16;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_INIT     = 4'd1;
    localparam logic [3:0] ST_INIT_CHK = 4'd2;
    localparam logic [3:0] ST_PROBE    = 4'd3;
    localparam logic [3:0] ST_CHECK    = 4'd4;
    localparam logic [3:0] ST_NEXT     = 4'd5;
    localparam logic [3:0] ST_POP      = 4'd6;
    localparam logic [3:0] ST_SOLVED   = 4'd7;
    localparam logic [3:0] ST_REPLAY   = 4'd8;
    localparam logic [3:0] ST_FAILED   = 4'd9;

    typedef struct packed {
        logic          ok;
        logic [CW-1:0] row;
        logic [CW-1:0] col;
    } nbr_t;

    // Up<->down and left<->right differ only in bit 1.
    function automatic logic [1:0] opposite(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

    // last = 2^N-1; stepping off any edge clears ok (no wrap-around).
    function automatic nbr_t neighbour(input logic [CW-1:0] row,
                                       input logic [CW-1:0] col,
                                       input logic [1:0]    d,
                                       input logic [CW-1:0] last);
        nbr_t r;
        r.ok  = 1'b1;
        r.row = row;
        r.col = col;
        case (d)
            DIR_UP:    if (row == '0)   r.ok = 1'b0; else r.row = row - 1'b1;
            DIR_RIGHT: if (col == last) r.ok = 1'b0; else r.col = col + 1'b1;
            DIR_DOWN:  if (row == last) r.ok = 1'b0; else r.row = row + 1'b1;
            default:   if (col == '0)   r.ok = 1'b0; else r.col = col - 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/maze_solver_ctrl_stack.sv
// Direction stack for the DFS path.
//   clk, rst      : clock, synchronous active-low reset (pointer only)
//   clear         : drop all entries
//   push/push_dir : append a direction
//   pop           : discard the top entry (ignored when empty)
//   rd_idx/rd_dir : random read for path replay (entry 0 = first step)
//   top_dir       : current top entry
//   sp, empty     : entry count and empty flag
module dir_stack
    import maze_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  logic        pop,
    input  logic [1:0]  push_dir,
    input  logic [AW-1:0] rd_idx,
    output logic [1:0]  rd_dir,
    output logic [1:0]  top_dir,
    output logic [AW:0] sp,
    output logic        empty
);

    logic [1:0]  mem [DEPTH];
    logic [AW:0] sp_m1;

    assign empty   = (sp == '0);
    assign sp_m1   = sp - 1'b1;
    assign top_dir = mem[sp_m1[AW-1:0]];
    assign rd_dir  = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst)               sp <= '0;
        else if (clear)         sp <= '0;
        else if (push)          sp <= sp + 1'b1;
        else if (pop && !empty) sp <= sp_m1;
    end

    // Contents are deliberately not reset: a solved path survives until overwritten.
    always_ff @(posedge clk) begin
        if (push) mem[sp[AW-1:0]] <= push_dir;
    end

endmodule

// File: rtl/maze_solver_ctrl.sv
// Depth-first-search maze controller with path replay.
//   clk, rst   : clock, synchronous active-low reset
//   start, run : begin search / begin replay of the solved path
//   mem_rd, mem_wr, mem_addr, mem_dout : single-port maze RAM
//                (dout valid the cycle after mem_rd, write data is always 1)
//   busy, done, fail : status
//   move, dir  : one pulse per replayed step with its direction
// All outputs decode from state so reset clears them on the next cycle.
module maze_solver_ctrl
    import maze_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 2**(2*N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           run,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic [2*N-1:0] mem_addr,
    input  logic           mem_dout,
    output logic           busy,
    output logic           done,
    output logic           fail,
    output logic           move,
    output logic [1:0]     dir
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST = CW'((1 << N) - 1);

    logic [3:0]    state;
    logic [N-1:0]  row, col;
    logic [1:0]    d;
    logic [AW-1:0] idx;

    logic          st_clear, st_push, st_pop, st_empty;
    logic [1:0]    top_dir, rd_dir, probe_dir;
    logic [AW:0]   sp, sp_last;
    logic          idle_like, at_goal;
    nbr_t          nb;

    // One neighbour computation serves both probing (direction d) and
    // backtracking (reverse of the popped direction).
    assign probe_dir = (state == ST_POP) ? opposite(top_dir) : d;
    assign nb        = neighbour(CW'(row), CW'(col), probe_dir, LAST);
    assign at_goal   = (nb.row == LAST) && (nb.col == LAST);
    assign sp_last   = sp - 1'b1;
    assign idle_like = (state == ST_IDLE) || (state == ST_SOLVED) || (state == ST_FAILED);

    assign st_clear = idle_like && start;
    assign st_push  = (state == ST_CHECK) && !mem_dout;
    assign st_pop   = (state == ST_POP) && !st_empty;

    dir_stack #(.DEPTH(DEPTH)) u_stack (
        .clk      (clk),
        .rst      (rst),
        .clear    (st_clear),
        .push     (st_push),
        .pop      (st_pop),
        .push_dir (d),
        .rd_idx   (idx),
        .rd_dir   (rd_dir),
        .top_dir  (top_dir),
        .sp       (sp),
        .empty    (st_empty)
    );

    assign mem_rd   = (state == ST_INIT) || ((state == ST_PROBE) && nb.ok);
    assign mem_wr   = ((state == ST_INIT_CHK) || (state == ST_CHECK)) && !mem_dout;
    // CHECK keeps d and pos from PROBE, so the write hits the cell just read.
    assign mem_addr = ((state == ST_PROBE) || (state == ST_CHECK))
                      ? {nb.row[N-1:0], nb.col[N-1:0]} : '0;
    assign busy     = !idle_like;
    assign done     = (state == ST_SOLVED) || (state == ST_REPLAY);
    assign fail     = (state == ST_FAILED);
    assign move     = (state == ST_REPLAY);
    assign dir      = (state == ST_REPLAY) ? rd_dir : 2'd0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            row   <= '0;
            col   <= '0;
            d     <= DIR_UP;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_FAILED, ST_SOLVED: begin
                    if (start) begin
                        state <= ST_INIT;
                        row   <= '0;
                        col   <= '0;
                    end else if (run && state == ST_SOLVED) begin
                        state <= ST_REPLAY;
                        idx   <= '0;
                    end
                end
                ST_INIT:     state <= ST_INIT_CHK;
                ST_INIT_CHK: begin
                    if (mem_dout) state <= ST_FAILED;
                    else begin
                        d     <= DIR_UP;
                        state <= ST_PROBE;
                    end
                end
                ST_PROBE:    state <= nb.ok ? ST_CHECK : ST_NEXT;
                ST_CHECK: begin
                    if (!mem_dout) begin
                        row   <= nb.row[N-1:0];
                        col   <= nb.col[N-1:0];
                        d     <= DIR_UP;
                        state <= at_goal ? ST_SOLVED : ST_PROBE;
                    end else begin
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (d != DIR_LEFT) begin
                        d     <= d + 2'd1;
                        state <= ST_PROBE;
                    end else begin
                        state <= ST_POP;
                    end
                end
                ST_POP: begin
                    if (st_empty) state <= ST_FAILED;
                    else begin
                        row <= nb.row[N-1:0];
                        col <= nb.col[N-1:0];
                        // A popped LEFT leaves nothing to probe here: keep popping.
                        if (top_dir != DIR_LEFT) begin
                            d     <= top_dir + 2'd1;
                            state <= ST_PROBE;
                        end
                    end
                end
                ST_REPLAY: begin
                    idx <= idx + 1'b1;
                    if ({1'b0, idx} == sp_last) state <= ST_SOLVED;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
